// File: rtl/key_input_hub.sv
// Multi-channel push-button front end: synchroniser, debouncer and
// press/release/long-press/typematic event generation per key.
module key_input_hub #(
    parameter int NUM_KEYS        = 5,
    parameter int ACTIVE_LOW      = 1,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int LONG_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [NUM_KEYS-1:0] KEY_IN,
    input  logic [NUM_KEYS-1:0] REPEAT_EN,
    output logic [NUM_KEYS-1:0] KEY_LEVEL,
    output logic [NUM_KEYS-1:0] KEY_PRESS,
    output logic [NUM_KEYS-1:0] KEY_RELEASE,
    output logic [NUM_KEYS-1:0] KEY_LONG,
    output logic [NUM_KEYS-1:0] KEY_REPEAT,
    output logic                KEY_ANY
);

    localparam int HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int DW       = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int HW       = $clog2(HOLD_MAX) + 1;
    localparam logic          POL      = (ACTIVE_LOW != 0);
    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] LNG_LAST = HW'(LONG_CYCLES - 1);
    localparam logic [HW-1:0] REP_LAST = HW'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_HELD, ST_LONGH} state_t;

    logic [NUM_KEYS-1:0] r_sync1, r_sync2;
    logic [NUM_KEYS-1:0] r_level, r_press, r_release, r_long, r_repeat;
    logic                r_any;
    logic [DW-1:0]       r_db    [NUM_KEYS];
    logic [HW-1:0]       r_hold  [NUM_KEYS];
    state_t              r_state [NUM_KEYS];

    logic [NUM_KEYS-1:0] w_s, w_level_nx, w_rise, w_fall, w_long_nx, w_rep_nx;
    logic [DW-1:0]       w_db_nx    [NUM_KEYS];
    logic [HW-1:0]       w_hold_nx  [NUM_KEYS];
    state_t              w_state_nx [NUM_KEYS];

    // Synchroniser holds raw pin values; its reset value is the idle pin level.
    assign w_s = r_sync2 ^ {NUM_KEYS{POL}};

    always_comb begin
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            w_db_nx[i]    = '0;
            w_level_nx[i] = r_level[i];
            w_rise[i]     = 1'b0;
            w_fall[i]     = 1'b0;
            w_state_nx[i] = r_state[i];
            w_hold_nx[i]  = r_hold[i];
            w_long_nx[i]  = 1'b0;
            w_rep_nx[i]   = 1'b0;

            if (w_s[i] != r_level[i]) begin
                if (r_db[i] == DB_LAST) begin
                    w_level_nx[i] = w_s[i];
                    w_rise[i]     = w_s[i];
                    w_fall[i]     = ~w_s[i];
                end else begin
                    w_db_nx[i] = r_db[i] + DW'(1);
                end
            end

            // Release is tested first so it masks a coincident LONG/REPEAT.
            case (r_state[i])
                ST_IDLE: begin
                    if (w_rise[i]) begin
                        w_state_nx[i] = ST_HELD;
                        w_hold_nx[i]  = '0;
                        w_rep_nx[i]   = 1'b1;
                    end
                end
                ST_HELD: begin
                    if (w_fall[i]) begin
                        w_state_nx[i] = ST_IDLE;
                        w_hold_nx[i]  = '0;
                    end else if (r_hold[i] == LNG_LAST) begin
                        w_state_nx[i] = ST_LONGH;
                        w_hold_nx[i]  = '0;
                        w_long_nx[i]  = 1'b1;
                    end else begin
                        w_hold_nx[i] = r_hold[i] + HW'(1);
                    end
                end
                ST_LONGH: begin
                    if (w_fall[i]) begin
                        w_state_nx[i] = ST_IDLE;
                        w_hold_nx[i]  = '0;
                    end else if (!REPEAT_EN[i]) begin
                        w_hold_nx[i] = '0;
                    end else if (r_hold[i] == REP_LAST) begin
                        w_hold_nx[i] = '0;
                        w_rep_nx[i]  = 1'b1;
                    end else begin
                        w_hold_nx[i] = r_hold[i] + HW'(1);
                    end
                end
                default: begin
                    w_state_nx[i] = ST_IDLE;
                    w_hold_nx[i]  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_sync1   <= {NUM_KEYS{POL}};
            r_sync2   <= {NUM_KEYS{POL}};
            r_level   <= '0;
            r_press   <= '0;
            r_release <= '0;
            r_long    <= '0;
            r_repeat  <= '0;
            r_any     <= 1'b0;
            for (int unsigned i = 0; i < NUM_KEYS; i++) begin
                r_db[i]    <= '0;
                r_hold[i]  <= '0;
                r_state[i] <= ST_IDLE;
            end
        end else begin
            r_sync1   <= KEY_IN;
            r_sync2   <= r_sync1;
            r_level   <= w_level_nx;
            r_press   <= w_rise;
            r_release <= w_fall;
            r_long    <= w_long_nx;
            r_repeat  <= w_rep_nx;
            r_any     <= |r_press;
            for (int unsigned i = 0; i < NUM_KEYS; i++) begin
                r_db[i]    <= w_db_nx[i];
                r_hold[i]  <= w_hold_nx[i];
                r_state[i] <= w_state_nx[i];
            end
        end
    end

    assign KEY_LEVEL   = r_level;
    assign KEY_PRESS   = r_press;
    assign KEY_RELEASE = r_release;
    assign KEY_LONG    = r_long;
    assign KEY_REPEAT  = r_repeat;
    assign KEY_ANY     = r_any;

endmodule

// File: tb/tb_key_input_hub.sv
// Scoreboard bench for key_input_hub: stimulus pushes expected pulse events,
// a negedge monitor pops and compares whenever any output pulse appears.
module tb_key_input_hub;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] key_in, rep_en;
    logic [4:0] level, press, release_o, long_o, repeat_o;
    logic       any_o;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int         cyc;
        logic [4:0] p, r, l, rp, lv;
        logic       a;
    } ev_t;
    ev_t sb[$];

    key_input_hub #(
        .NUM_KEYS(5),
        .ACTIVE_LOW(1),
        .DEBOUNCE_CYCLES(4),
        .LONG_CYCLES(20),
        .REPEAT_CYCLES(5)
    ) dut (
        .CLK(clk),
        .RESET(rst),
        .KEY_IN(key_in),
        .REPEAT_EN(rep_en),
        .KEY_LEVEL(level),
        .KEY_PRESS(press),
        .KEY_RELEASE(release_o),
        .KEY_LONG(long_o),
        .KEY_REPEAT(repeat_o),
        .KEY_ANY(any_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int c, input logic [4:0] p, input logic [4:0] r,
                        input logic [4:0] l, input logic [4:0] rp,
                        input logic [4:0] lv, input logic a);
        ev_t e;
        e.cyc = c; e.p = p; e.r = r; e.l = l; e.rp = rp; e.lv = lv; e.a = a;
        sb.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Standard hold sequence: press/repeat at +6, KEY_ANY at +7, long at +26.
    task automatic push_press_long(input int c0, input logic [4:0] m);
        push(c0 + 6,  m, '0, '0, m,  m, 1'b0);
        push(c0 + 7,  '0, '0, '0, '0, m, 1'b1);
        push(c0 + 26, '0, '0, m,  '0, m, 1'b0);
    endtask

    initial begin
        int c0;
        rst    = 1'b1;
        key_in = 5'b11111;
        rep_en = 5'b00000;

        fork
            forever begin
                ev_t e;
                @(negedge clk);
                if (!rst) begin
                    if ((|{press, release_o, long_o, repeat_o, any_o}) === 1'b1) begin
                        checks++;
                        if (sb.size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_pulse cyc=%0d p=%b r=%b l=%b rp=%b a=%b lv=%b exp=none",
                                     cyc, press, release_o, long_o, repeat_o, any_o, level);
                        end else begin
                            e = sb.pop_front();
                            if (e.cyc != cyc || e.p !== press || e.r !== release_o || e.l !== long_o ||
                                e.rp !== repeat_o || e.lv !== level || e.a !== any_o) begin
                                errors++;
                                $display("FAIL event got cyc=%0d p=%b r=%b l=%b rp=%b lv=%b a=%b exp cyc=%0d p=%b r=%b l=%b rp=%b lv=%b a=%b",
                                         cyc, press, release_o, long_o, repeat_o, level, any_o,
                                         e.cyc, e.p, e.r, e.l, e.rp, e.lv, e.a);
                            end
                        end
                    end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
                        checks++;
                        errors++;
                        e = sb.pop_front();
                        $display("FAIL missing_event at cyc=%0d got=no_pulse exp cyc=%0d p=%b r=%b l=%b rp=%b a=%b",
                                 cyc, e.cyc, e.p, e.r, e.l, e.rp, e.a);
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {6'd0, level, press, release_o, long_o, repeat_o, any_o}, 32'd0);
        rst = 1'b0;
        tick(5);

        // Clean press on key 1, held 100 cycles, no auto-repeat.
        c0 = cyc;
        push_press_long(c0, 5'b00010);
        push(c0 + 106, '0, 5'b00010, '0, '0, '0, 1'b0);
        key_in[1] = 1'b0;
        tick(100);
        key_in[1] = 1'b1;
        tick(12);

        // Bouncy key 3: never stable for 4 cycles.
        key_in[3] = 1'b0; tick(3);
        key_in[3] = 1'b1; tick(1);
        key_in[3] = 1'b0; tick(3);
        key_in[3] = 1'b1; tick(10);
        check("bounce_level", {27'd0, level}, 32'd0);

        // Auto-repeat on key 4: 12 repeats then release.
        rep_en = 5'b10000;
        c0 = cyc;
        push_press_long(c0, 5'b10000);
        for (int k = 1; k <= 12; k++) push(c0 + 26 + 5 * k, '0, '0, '0, 5'b10000, 5'b10000, 1'b0);
        push(c0 + 88, '0, 5'b10000, '0, '0, '0, 1'b0);
        key_in[4] = 1'b0;
        tick(82);
        key_in[4] = 1'b1;
        tick(12);

        // Same stimulus with repeat disabled: no repeats after the press.
        rep_en = 5'b00000;
        c0 = cyc;
        push_press_long(c0, 5'b10000);
        push(c0 + 88, '0, 5'b10000, '0, '0, '0, 1'b0);
        key_in[4] = 1'b0;
        tick(82);
        key_in[4] = 1'b1;
        tick(12);

        // Release lands on the edge the 12th repeat would fire: repeat suppressed.
        rep_en = 5'b10000;
        c0 = cyc;
        push_press_long(c0, 5'b10000);
        for (int k = 1; k <= 11; k++) push(c0 + 26 + 5 * k, '0, '0, '0, 5'b10000, 5'b10000, 1'b0);
        push(c0 + 86, '0, 5'b10000, '0, '0, '0, 1'b0);
        key_in[4] = 1'b0;
        tick(80);
        key_in[4] = 1'b1;
        tick(12);
        rep_en = 5'b00000;

        // Short hold on key 0: release 10 cycles after press, no long.
        c0 = cyc;
        push(c0 + 6,  5'b00001, '0, '0, 5'b00001, 5'b00001, 1'b0);
        push(c0 + 7,  '0, '0, '0, '0, 5'b00001, 1'b1);
        push(c0 + 16, '0, 5'b00001, '0, '0, '0, 1'b0);
        key_in[0] = 1'b0;
        tick(10);
        key_in[0] = 1'b1;
        tick(12);

        // Simultaneous keys 2 and 4.
        c0 = cyc;
        push_press_long(c0, 5'b10100);
        push(c0 + 36, '0, 5'b10100, '0, '0, '0, 1'b0);
        key_in = 5'b01011;
        tick(30);
        key_in = 5'b11111;
        tick(12);

        // Reset during long hold on key 1; key stays held through reset.
        c0 = cyc;
        push_press_long(c0, 5'b00010);
        key_in[1] = 1'b0;
        tick(30);
        rst = 1'b1;
        #1;
        check("reset_mid_hold", {6'd0, level, press, release_o, long_o, repeat_o, any_o}, 32'd0);
        tick(3);
        rst = 1'b0;
        c0 = cyc;
        push(c0 + 6,  5'b00010, '0, '0, 5'b00010, 5'b00010, 1'b0);
        push(c0 + 7,  '0, '0, '0, '0, 5'b00010, 1'b1);
        push(c0 + 16, '0, 5'b00010, '0, '0, '0, 1'b0);
        tick(10);
        key_in[1] = 1'b1;
        tick(12);

        check("scoreboard_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
